// File: rtl/neuron_sched_pkg.sv
// neuron_sched_pkg: FSM state encoding and default timing constants for neuron_scheduler
package neuron_sched_pkg;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_SETTLE  = 3'd1;
  localparam state_t S_CONVERT = 3'd2;
  localparam state_t S_COMPARE = 3'd3;
  localparam state_t S_PULSE   = 3'd4;
  localparam int DEF_NUM_CH         = 4;
  localparam int DEF_SETTLE_CYCLES  = 8;
  localparam int DEF_ADC_TIMEOUT    = 255;
  localparam int DEF_PULSE_CYCLES   = 104;
  localparam int DEF_REFRACT_CYCLES = 1040;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant, searching upward from ptr with wraparound
module rr_arbiter #(
  parameter int N = 4,
  localparam int W = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant
);
  logic found;
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++)
        if (!found && req[k] && k == (int'(ptr) + i) % N) begin
          grant[k] = 1'b1;
          found = 1'b1;
        end
  end
endmodule

// File: rtl/neuron_scheduler.sv
// neuron_scheduler: round-robin sharing of one ADC/threshold path across neuron channels
module neuron_scheduler
  import neuron_sched_pkg::*;
#(
  parameter int NUM_CH         = DEF_NUM_CH,
  parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int ADC_TIMEOUT    = DEF_ADC_TIMEOUT,
  parameter int PULSE_CYCLES   = DEF_PULSE_CYCLES,
  parameter int REFRACT_CYCLES = DEF_REFRACT_CYCLES,
  localparam int W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic                CLK104MHZ,
  input  logic                reset,
  input  logic [NUM_CH-1:0]   fireNeuron,
  input  logic signed [11:0]  threshold,
  input  logic signed [11:0]  ADC_OUT,
  input  logic                adc_valid,
  output logic [W-1:0]        adc_sel,
  output logic                adc_start,
  output logic [NUM_CH-1:0]   pulse_out,
  output logic                busy,
  output logic                timeout_err
);
  localparam int RW = $clog2(REFRACT_CYCLES + 1);
  state_t state;
  logic [15:0] cnt;
  logic [W-1:0] ptr, gidx;
  logic [NUM_CH-1:0] pending, elig, grant, refr_zero;
  logic signed [11:0] sample;
  logic pulse_end;

  assign elig = pending & refr_zero;
  rr_arbiter #(.N(NUM_CH)) u_arb (.req(elig), .ptr(ptr), .grant(grant));

  always_comb begin
    gidx = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (grant[k]) gidx = W'(k);
  end

  // strobes and pulse decode straight from state so reset clears them immediately
  assign busy      = state != S_IDLE;
  assign adc_start = state == S_CONVERT && cnt == '0;
  assign pulse_out = state == S_PULSE ? NUM_CH'(1) << adc_sel : '0;
  assign pulse_end = state == S_PULSE && cnt == 16'(PULSE_CYCLES - 1);

  always_ff @(posedge CLK104MHZ or posedge reset)
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      ptr         <= '0;
      adc_sel     <= '0;
      sample      <= '0;
      pending     <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      cnt         <= cnt + 16'd1;
      pending     <= (pending & ~(state == S_IDLE ? grant : '0)) | fireNeuron;
      case (state)
        S_IDLE:
          if (|grant) begin
            state   <= S_SETTLE;
            adc_sel <= gidx;
            ptr     <= gidx == W'(NUM_CH - 1) ? '0 : gidx + 1'b1;
            cnt     <= '0;
          end
        S_SETTLE:
          if (cnt == 16'(SETTLE_CYCLES - 1)) begin
            state <= S_CONVERT;
            cnt   <= '0;
          end
        S_CONVERT:
          if (adc_valid) begin
            sample <= ADC_OUT;
            state  <= S_COMPARE;
          end else if (cnt == 16'(ADC_TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            state       <= S_IDLE;
          end
        S_COMPARE: begin
          state <= sample > threshold ? S_PULSE : S_IDLE;
          cnt   <= '0;
        end
        S_PULSE:
          if (pulse_end) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_refr
    logic [RW-1:0] rc;
    always_ff @(posedge CLK104MHZ or posedge reset)
      if (reset) rc <= '0;
      else if (pulse_end && adc_sel == W'(g)) rc <= RW'(REFRACT_CYCLES);
      else if (rc != '0) rc <= rc - 1'b1;
    assign refr_zero[g] = rc == '0;
  end
endmodule
